// File: rtl/i2c_peripheral.sv
// i2c_peripheral: I2C target with a fixed 7-bit address, byte-level rx/tx handshakes
// and open-drain emulation on SDA (sda_oe) and SCL (scl_oe).
// SCL/SDA are oversampled on clk; the system clock must run at least 8x the SCL rate.
// Optional build macro: I2C_CLOCK_STRETCH_EN -- hold SCL low while no tx byte is
// available at a read load; without it an underrun returns 8'hFF.
module i2c_peripheral #(
    parameter logic [6:0] ADDRESS     = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic       busy,
    output logic       write_mode,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_taken,
    output logic       transfer_done
);

    // Never fewer than two synchroniser flops, whatever the parameter says.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_DATA   = 3'd3,
        WR_ACK    = 3'd4,
        RD_DATA   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    // Synchronisers and previous-sample flops for edge detection.
    logic [SYNC_N-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_N-1:0] sda_sync_q, sda_sync_d;
    logic              scl_prev_q, sda_prev_q;

    // Protocol state.
    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        sda_oe_q, sda_oe_d;
    logic        scl_oe_q, scl_oe_d;
    logic        busy_q, busy_d;
    logic        write_mode_q, write_mode_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_taken_q, tx_taken_d;
    logic        transfer_done_q, transfer_done_d;

    // Decoded bus events.
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall;
    logic       start_det, stop_det;
    logic [7:0] rx_byte;
    logic       load_tx;

    assign scl_s = scl_sync_q[SYNC_N-1];
    assign sda_s = sda_sync_q[SYNC_N-1];

    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    // START/STOP only count while SCL has been high for both samples.
    assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

    // Byte as it stands once the bit on SDA right now is shifted in.
    assign rx_byte = {shift_q[6:0], sda_s};

    // Shift raw pad inputs into the synchroniser chains.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_N-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_N-2:0], sda_in};
    end

    // Next-state and output logic of the target FSM.
    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        sda_oe_d        = sda_oe_q;
        scl_oe_d        = scl_oe_q;
        busy_d          = busy_q;
        write_mode_d    = write_mode_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = 1'b0;
        tx_taken_d      = 1'b0;
        transfer_done_d = 1'b0;
        load_tx         = 1'b0;

        if (stop_det) begin
            state_d         = IDLE;
            sda_oe_d        = 1'b0;
            scl_oe_d        = 1'b0;
            busy_d          = 1'b0;
            bit_cnt_d       = 3'd0;
            transfer_done_d = busy_q;
        end else if (start_det) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd0;
        end else if (scl_oe_q) begin
            // Clock is being stretched: the pending load completes once data arrives.
            load_tx = tx_valid;
        end else begin
            case (state_q)
                IDLE: begin
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == ADDRESS) begin
                                write_mode_d = ~rx_byte[0];
                                busy_d       = 1'b1;
                                state_d      = ADDR_ACK;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end
                    end
                end

                // First fall after the 8th bit asserts ACK; the fall ending the
                // 9th clock releases it, so sda_oe_q itself marks the ACK phase.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (write_mode_q) begin
                                state_d = WR_DATA;
                            end else begin
                                load_tx = 1'b1;
                            end
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = rx_byte;
                            rx_valid_d = 1'b1;
                            state_d    = rx_ready ? WR_ACK : WAIT_STOP;
                        end
                    end
                end

                // The MSB was put on the bus at load; each rise consumes a bit and
                // each later fall presents the next one. After eight rises the
                // counter has wrapped to 0 and that fall releases SDA for the ACK.
                RD_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], 1'b1};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = RD_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        load_tx = 1'b1;
                    end
                end

                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end

        // Load the next read byte and present its MSB immediately.
        if (load_tx) begin
            bit_cnt_d = 3'd0;
            if (tx_valid) begin
                shift_d    = tx_data;
                tx_taken_d = 1'b1;
                sda_oe_d   = ~tx_data[7];
                scl_oe_d   = 1'b0;
                state_d    = RD_DATA;
            end else begin
`ifdef I2C_CLOCK_STRETCH_EN
                sda_oe_d = 1'b0;
                scl_oe_d = 1'b1;
`else
                shift_d  = 8'hFF;
                sda_oe_d = 1'b0;
                state_d  = RD_DATA;
`endif
            end
        end
    end

    // Register update; synchronisers and edge history preset to the idle bus level.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q      <= '1;
            sda_sync_q      <= '1;
            scl_prev_q      <= 1'b1;
            sda_prev_q      <= 1'b1;
            state_q         <= IDLE;
            shift_q         <= 8'h00;
            bit_cnt_q       <= 3'd0;
            sda_oe_q        <= 1'b0;
            scl_oe_q        <= 1'b0;
            busy_q          <= 1'b0;
            write_mode_q    <= 1'b0;
            rx_data_q       <= 8'h00;
            rx_valid_q      <= 1'b0;
            tx_taken_q      <= 1'b0;
            transfer_done_q <= 1'b0;
        end else begin
            scl_sync_q      <= scl_sync_d;
            sda_sync_q      <= sda_sync_d;
            scl_prev_q      <= scl_s;
            sda_prev_q      <= sda_s;
            state_q         <= state_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            sda_oe_q        <= sda_oe_d;
            scl_oe_q        <= scl_oe_d;
            busy_q          <= busy_d;
            write_mode_q    <= write_mode_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            tx_taken_q      <= tx_taken_d;
            transfer_done_q <= transfer_done_d;
        end
    end

    // Reset releases the bus in the very cycle it is asserted, not one edge later.
    assign sda_out = 1'b0;
    assign sda_oe  = sda_oe_q & ~reset;
`ifdef I2C_CLOCK_STRETCH_EN
    assign scl_oe  = scl_oe_q & ~reset;
`else
    assign scl_oe  = 1'b0;
`endif

    assign busy          = busy_q;
    assign write_mode    = write_mode_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign tx_taken      = tx_taken_q;
    assign transfer_done = transfer_done_q;

endmodule

// File: tb/tb_i2c_peripheral.sv
// tb_i2c_peripheral: bus-functional I2C master driving i2c_peripheral, with a
// scoreboard of expected written and read bytes.
`timescale 1ns/1ps
module tb_i2c_peripheral;
    localparam int Q = 40;  // quarter SCL period in ns (SCL = 16 system clocks)

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       scl_in, sda_in;
    logic       sda_out, sda_oe, scl_oe;
    logic       busy, write_mode;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_taken, transfer_done;

    int n_cmp = 0;
    int n_bad = 0;
    int tdone_cnt = 0;
    int taken_cnt = 0;
    int rx_cnt = 0;
    bit sda_driven = 1'b0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] rd_exp_q[$];

    always #5 clk = ~clk;

    // Wired-AND open-drain bus between the master model and the target.
    assign scl_in = scl_m & ~scl_oe;
    assign sda_in = sda_m & ~sda_oe;

    i2c_peripheral #(.ADDRESS(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
        .sda_out(sda_out), .sda_oe(sda_oe), .scl_oe(scl_oe),
        .busy(busy), .write_mode(write_mode),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_taken(tx_taken),
        .transfer_done(transfer_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pulse counters and rx scoreboard pops.
    always @(negedge clk) begin
        if (transfer_done) tdone_cnt++;
        if (tx_taken) taken_cnt++;
        if (sda_oe) sda_driven = 1'b1;
        if (rx_valid) begin
            rx_cnt++;
            if (rx_exp_q.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
            else check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_scl_high();
        int n = 0;
        while (scl_in !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("scl_release_timeout", 32'd0, 32'd1);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; wait_scl_high(); #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; wait_scl_high(); #Q;
        b = sda_in; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; wait_scl_high(); #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; wait_scl_high(); #Q;
        sda_m = 1'b1; #(2*Q);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         td0, tk0, rx0;

        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_outs_in_reset", {22'd0, sda_out, sda_oe, scl_oe, busy, write_mode,
              rx_valid, tx_taken, transfer_done}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Addressed write of two bytes.
        td0 = tdone_cnt;
        rx_exp_q.push_back(8'h12);
        rx_exp_q.push_back(8'h34);
        i2c_start();
        wr_byte(8'hA0, ack); check("wr_addr_ack", {31'd0, ack}, 32'd0);
        check("wr_busy", {31'd0, busy}, 32'd1);
        check("wr_write_mode", {31'd0, write_mode}, 32'd1);
        wr_byte(8'h12, ack); check("wr_d0_ack", {31'd0, ack}, 32'd0);
        wr_byte(8'h34, ack); check("wr_d1_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("wr_tdone", tdone_cnt - td0, 32'd1);
        check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
        check("wr_rx_all_seen", rx_exp_q.size(), 32'd0);

        // Wrong address: the target must stay off the bus.
        td0 = tdone_cnt; rx0 = rx_cnt; sda_driven = 1'b0;
        i2c_start();
        wr_byte(8'hA2, ack); check("na_addr_nack", {31'd0, ack}, 32'd1);
        check("na_busy", {31'd0, busy}, 32'd0);
        wr_byte(8'h12, ack); check("na_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("na_sda_never_driven", {31'd0, sda_driven}, 32'd0);
        check("na_no_rx", rx_cnt - rx0, 32'd0);
        check("na_no_tdone", tdone_cnt - td0, 32'd0);

        // Read two bytes, master ACKs the first and NACKs the second.
        td0 = tdone_cnt; tk0 = taken_cnt;
        tx_valid = 1'b1; tx_data = 8'h5A;
        rd_exp_q.push_back(8'h5A);
        rd_exp_q.push_back(8'hC3);
        i2c_start();
        wr_byte(8'hA1, ack); check("rd_addr_ack", {31'd0, ack}, 32'd0);
        check("rd_write_mode", {31'd0, write_mode}, 32'd0);
        rd_byte(d); check("rd_byte0", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
        tx_data = 8'hC3;
        bit_out(1'b0);
        rd_byte(d); check("rd_byte1", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
        bit_out(1'b1);
        check("rd_wait_stop", {29'd0, dut.state_q}, {29'd0, ST_WAIT});
        i2c_stop();
        repeat (4) @(negedge clk);
        check("rd_taken", taken_cnt - tk0, 32'd2);
        check("rd_tdone", tdone_cnt - td0, 32'd1);
        check("rd_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});

        // Data byte NACKed by user logic; later bytes ignored.
        rx0 = rx_cnt;
        rx_ready = 1'b0;
        rx_exp_q.push_back(8'h77);
        i2c_start();
        wr_byte(8'hA0, ack); check("nk_addr_ack", {31'd0, ack}, 32'd0);
        wr_byte(8'h77, ack); check("nk_data_nack", {31'd0, ack}, 32'd1);
        wr_byte(8'h55, ack); check("nk_next_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("nk_rx_once", rx_cnt - rx0, 32'd1);

        // Write, repeated START, then read one byte.
        rx_exp_q.push_back(8'h01);
        i2c_start();
        wr_byte(8'hA0, ack); check("rs_addr_w_ack", {31'd0, ack}, 32'd0);
        check("rs_wm_write", {31'd0, write_mode}, 32'd1);
        wr_byte(8'h01, ack); check("rs_d_ack", {31'd0, ack}, 32'd0);
        i2c_start();
        check("rs_busy_dropped", {31'd0, busy}, 32'd0);
        tx_data = 8'h9C;
        rd_exp_q.push_back(8'h9C);
        wr_byte(8'hA1, ack); check("rs_addr_r_ack", {31'd0, ack}, 32'd0);
        check("rs_wm_read", {31'd0, write_mode}, 32'd0);
        check("rs_busy_again", {31'd0, busy}, 32'd1);
        rd_byte(d); check("rs_rd_byte", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
        bit_out(1'b1);
        i2c_stop();
        repeat (4) @(negedge clk);

        // Read underrun: tx_valid low at the load point.
        tk0 = taken_cnt;
        tx_valid = 1'b0; tx_data = 8'h00;
        i2c_start();
        wr_byte(8'hA1, ack); check("ur_addr_ack", {31'd0, ack}, 32'd0);
`ifdef I2C_CLOCK_STRETCH_EN
        rd_exp_q.push_back(8'hE7);
        fork
            begin
                int held;
                held = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (scl_oe === 1'b1) held++;
                end
                check("ur_stretch_held", held, 32'd20);
                tx_data = 8'hE7; tx_valid = 1'b1;
            end
            rd_byte(d);
        join
        check("ur_rd_byte", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
        check("ur_taken", taken_cnt - tk0, 32'd1);
`else
        rd_exp_q.push_back(8'hFF);
        check("ur_scl_oe_tied", {31'd0, scl_oe}, 32'd0);
        rd_byte(d); check("ur_rd_byte", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
        check("ur_taken", taken_cnt - tk0, 32'd0);
`endif
        bit_out(1'b1);
        i2c_stop();
        repeat (4) @(negedge clk);

        // Reset in the middle of a read byte while SDA is pulled low.
        tx_valid = 1'b1; tx_data = 8'h00;
        i2c_start();
        wr_byte(8'hA1, ack); check("rm_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 3; i++) bit_in(ack);
        check("rm_sda_oe_before", {31'd0, sda_oe}, 32'd1);
        reset = 1'b1;
        #1;
        check("rm_sda_released", {31'd0, sda_oe}, 32'd0);
        @(posedge clk); #1;
        check("rm_state_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
        check("rm_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        i2c_stop();
        repeat (4) @(negedge clk);
        check("rm_idle_after", {29'd0, dut.state_q}, {29'd0, ST_IDLE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
